// File: rtl/mgt_01_mul_unit_if.sv
// Shared operation/state encodings and the request/response bundle of the
// iterative multiplier.
package mgt_01_mul_unit_pkg;
    typedef enum logic [1:0] {MUL_ = 2'd0, MULH_ = 2'd1, MULHSU_ = 2'd2, MULHU_ = 2'd3} mul_ops_e;
    typedef enum logic {FREE = 1'b0, BUSY = 1'b1} fu_state_e;
endpackage

interface mgt_01_mul_unit_if #(parameter int XLEN = 32);
    import mgt_01_mul_unit_pkg::*;

    logic            valid_i;
    logic [XLEN-1:0] multiplicand_i;
    logic [XLEN-1:0] multiplier_i;
    mul_ops_e        operation_i;
    logic [XLEN-1:0] result_o;
    logic            valid_o;
    fu_state_e       fu_state_o;

    modport master (output valid_i, multiplicand_i, multiplier_i, operation_i,
                    input  result_o, valid_o, fu_state_o);
    modport slave  (input  valid_i, multiplicand_i, multiplier_i, operation_i,
                    output result_o, valid_o, fu_state_o);
endinterface

// File: rtl/mgt_01_mul_unit.sv
// Iterative radix-4 Booth multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// One Booth digit per enabled cycle, 17 digits over 34-bit extended operands.
module mgt_01_mul_unit
    import mgt_01_mul_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clk_en_i,
    mgt_01_mul_unit_if.slave    bus
);
    localparam int OW   = XLEN + 2;      // extended operand width
    localparam int PW   = OW + 2;        // partial product width (digit up to +/-2)
    localparam int AW   = 2 * OW;        // accumulator width
    localparam int LAST = OW / 2 - 1;    // index of final Booth digit
    localparam int CW   = $clog2(LAST + 2);

    typedef enum logic [1:0] {IDLE, MULTIPLY, RESULT} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [OW-1:0]   mc_q, mc_d;
    logic [OW-1:0]   mp_q, mp_d;
    logic            mprev_q, mprev_d;
    mul_ops_e        op_q, op_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            valid_q, valid_d;

    logic [PW-1:0]   pp;
    logic [AW-1:0]   partial;
    logic [AW-1:0]   acc_sum;

    always_comb begin
        pp = '0;
        unique case ({mp_q[1:0], mprev_q})
            3'b001, 3'b010: pp = {{2{mc_q[OW-1]}}, mc_q};
            3'b011:         pp = {mc_q[OW-1], mc_q, 1'b0};
            3'b100:         pp = -{mc_q[OW-1], mc_q, 1'b0};
            3'b101, 3'b110: pp = -{{2{mc_q[OW-1]}}, mc_q};
            default:        pp = '0;
        endcase
        // Weight by 4^k: the digit index is the iteration counter.
        partial = {{(AW-PW){pp[PW-1]}}, pp} << {cnt_q, 1'b0};
        acc_sum = acc_q + partial;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        mp_d     = mp_q;
        mprev_d  = mprev_q;
        op_d     = op_q;
        result_d = result_q;
        valid_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.valid_i) begin
                    state_d = MULTIPLY;
                    op_d    = bus.operation_i;
                    mc_d    = (bus.operation_i == MULHU_)
                            ? {2'b00, bus.multiplicand_i}
                            : {{2{bus.multiplicand_i[XLEN-1]}}, bus.multiplicand_i};
                    mp_d    = (bus.operation_i == MUL_ || bus.operation_i == MULH_)
                            ? {{2{bus.multiplier_i[XLEN-1]}}, bus.multiplier_i}
                            : {2'b00, bus.multiplier_i};
                    mprev_d = 1'b0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            MULTIPLY: begin
                acc_d   = acc_sum;
                mp_d    = {{2{mp_q[OW-1]}}, mp_q[OW-1:2]};
                mprev_d = mp_q[1];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(LAST)) begin
                    state_d  = RESULT;
                    valid_d  = 1'b1;
                    result_d = (op_q == MUL_) ? acc_sum[XLEN-1:0] : acc_sum[2*XLEN-1:XLEN];
                end
            end
            RESULT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mc_q     <= '0;
            mp_q     <= '0;
            mprev_q  <= 1'b0;
            op_q     <= MUL_;
            result_q <= '0;
            valid_q  <= 1'b0;
        end else if (clk_en_i) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mp_q     <= mp_d;
            mprev_q  <= mprev_d;
            op_q     <= op_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.result_o   = result_q;
    assign bus.valid_o    = valid_q;
    assign bus.fu_state_o = (state_q == IDLE) ? FREE : BUSY;
endmodule

// File: tb/tb_mgt_01_mul_unit.sv
// Scoreboard bench for the iterative multiplier: requests push expected
// results from a wide-arithmetic model, a monitor pops on each valid_o pulse.
module tb_mgt_01_mul_unit;
    import mgt_01_mul_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;
    always #5 clk = ~clk;

    mgt_01_mul_unit_if #(.XLEN(32)) bus ();
    mgt_01_mul_unit #(.XLEN(32)) dut (.clk_i(clk), .rst_i(rst), .clk_en_i(clk_en), .bus(bus));

    typedef struct {
        logic [31:0] res;
        int          acc_en;
        int          acc_cyc;
        int          extra;
    } exp_t;

    exp_t        sbq[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          en_edges = 0;
    int          vlen = 0;
    logic        vprev = 1'b0;
    logic [31:0] last_res = '0;

    always @(posedge clk) begin
        cyc++;
        if (clk_en && !rst) en_edges++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_mul(input mul_ops_e op, input logic [31:0] a, input logic [31:0] b);
        logic signed [127:0] sa, sb, p;
        sa = (op == MULHU_) ? $signed({96'b0, a}) : $signed({{96{a[31]}}, a});
        sb = (op == MUL_ || op == MULH_) ? $signed({{96{b[31]}}, b}) : $signed({96'b0, b});
        p  = sa * sb;
        return (op == MUL_) ? p[31:0] : p[63:32];
    endfunction

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue(input mul_ops_e op, input logic [31:0] a, input logic [31:0] b, input int extra);
        exp_t e;
        int   w = 0;
        while (bus.fu_state_o != FREE && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("issue_timeout", 64'd1, 64'd0);
        bus.valid_i        = 1'b1;
        bus.operation_i    = op;
        bus.multiplicand_i = a;
        bus.multiplier_i   = b;
        e.res     = ref_mul(op, a, b);
        e.acc_en  = en_edges + 1;
        e.acc_cyc = cyc + 1;
        e.extra   = extra;
        sbq.push_back(e);
        last_res = e.res;
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.valid_o && !vprev) begin
                if (sbq.size() == 0) chk("unexpected_valid", 64'd1, 64'd0);
                else begin
                    e = sbq.pop_front();
                    chk("result", {32'b0, bus.result_o}, {32'b0, e.res});
                    chk("latency_enabled_edges", 64'(en_edges - e.acc_en), 64'd17);
                    chk("latency_cycles", 64'(cyc - e.acc_cyc), 64'(17 + e.extra));
                end
            end
            if (bus.valid_o) vlen++;
            else if (vprev) begin
                chk("valid_width", 64'(vlen), 64'd1);
                vlen = 0;
            end
        end
        vprev = bus.valid_o;
    end

    initial begin
        int b;
        int w;
        logic [31:0] ra, rb;
        bus.valid_i        = 1'b0;
        bus.operation_i    = MUL_;
        bus.multiplicand_i = '0;
        bus.multiplier_i   = '0;

        #2;
        chk("rst_result", {32'b0, bus.result_o}, 64'd0);
        chk("rst_valid", {63'b0, bus.valid_o}, 64'd0);
        chk("rst_fu_state", {63'b0, bus.fu_state_o}, {63'b0, FREE});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        issue(MUL_, 32'd7, 32'hFFFFFFFD, 0);
        b = 0;
        while (bus.fu_state_o == BUSY && b < 100) begin
            b++;
            @(negedge clk);
        end
        chk("busy_cycles", 64'(b), 64'd18);
        chk("mul_neg_value", {32'b0, bus.result_o}, 64'hFFFFFFEB);
        repeat (3) @(negedge clk);
        chk("result_hold", {32'b0, bus.result_o}, {32'b0, last_res});

        issue(MULH_,   32'h80000000, 32'h80000000, 0);
        issue(MUL_,    32'h80000000, 32'h80000000, 0);
        issue(MULHU_,  32'hFFFFFFFF, 32'hFFFFFFFF, 0);
        issue(MULHSU_, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);

        // New request mid-operation must be ignored.
        issue(MUL_, 32'h00001234, 32'h00005678, 0);
        repeat (3) @(negedge clk);
        bus.valid_i        = 1'b1;
        bus.operation_i    = MULHU_;
        bus.multiplicand_i = 32'hCAFEBABE;
        bus.multiplier_i   = 32'h0BADF00D;
        repeat (2) @(negedge clk);
        bus.valid_i = 1'b0;

        // Clock-enable stall of 5 cycles mid-operation.
        issue(MULH_, 32'h9ABCDEF0, 32'h13579BDF, 5);
        repeat (6) @(negedge clk);
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;

        // Abort at iteration 8.
        issue(MULHU_, 32'hDEADBEEF, 32'h12345678, 0);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_result", {32'b0, bus.result_o}, 64'd0);
        chk("abort_valid", {63'b0, bus.valid_o}, 64'd0);
        chk("abort_fu_state", {63'b0, bus.fu_state_o}, {63'b0, FREE});
        void'(sbq.pop_back());
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("post_abort_fu_state", {63'b0, bus.fu_state_o}, {63'b0, FREE});
        issue(MULHU_, 32'h00010000, 32'h00010000, 0);

        issue(MUL_,  32'h00000000, 32'h12345678, 0);
        issue(MULH_, 32'h12345678, 32'h00000000, 0);

        repeat (24) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000;
            if ($urandom_range(0, 7) == 0) rb = 32'hFFFFFFFF;
            issue(mul_ops_e'($urandom_range(0, 3)), ra, rb, 0);
        end

        w = 0;
        while (sbq.size() != 0 && w < 200) begin
            @(negedge clk);
            w++;
        end
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
